brick_scan_sequencer: RTL and testbench



---
 rtl/breakout_pkg.sv | 39 +++
 rtl/brick_scan_sequencer_if.sv | 30 +++
 rtl/brick_overlap.sv | 24 ++
 rtl/brick_scan_sequencer.sv | 158 +++++++++++++++
 tb/tb_brick_scan_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/breakout_pkg.sv
// Breakout playfield geometry, colours and shared types used by the game-tick
// logic, the brick scan sequencer and the renderer.
package breakout_pkg;

   localparam int COORD_W       = 10;
   localparam int CMP_W         = COORD_W + 1;

   localparam int LEFT_WALL_X   = 240;
   localparam int RIGHT_WALL_X  = 800;
   localparam int CEILING_Y     = 25;
   localparam int FLOOR_Y       = 480;

   localparam int BRICK_COLS    = 12;
   localparam int BRICK_ROWS    = 5;
   localparam int BRICK_LEFT_X  = 250;
   localparam int BRICK_TOP_Y   = 35;
   localparam int BRICK_W       = 45;
   localparam int BRICK_H       = 25;
   localparam int BALL_R        = 5;
   localparam int PADDLE_HALF_W = 40;
   localparam int PADDLE_HALF_H = 5;

   localparam int NUM_BRICKS    = BRICK_COLS * BRICK_ROWS;
   localparam int BRICK_IDX_W   = $clog2(NUM_BRICKS);
   localparam int BRICK_CNT_W   = 6;

   typedef logic [11:0] rgb_t;
   localparam rgb_t COLOR_BG     = 12'h000;
   localparam rgb_t COLOR_WALL   = 12'hFFF;
   localparam rgb_t COLOR_BRICK  = 12'hF80;
   localparam rgb_t COLOR_BALL   = 12'hFF0;
   localparam rgb_t COLOR_PADDLE = 12'h0CF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_e;

endpackage

// File: rtl/brick_scan_sequencer_if.sv
// Handshake and status bundle between the game-tick FSM (master) and the
// brick scan sequencer (slave); hit_vec also fans out to the colour mux.
interface brick_scan_sequencer_if
   import breakout_pkg::*;
#(
   parameter int N_BRICKS = NUM_BRICKS
);
   logic                   start;
   logic                   clear_bricks;
   logic [COORD_W-1:0]     ball_x;
   logic [COORD_W-1:0]     ball_y;
   logic                   busy;
   logic                   done;
   logic                   hit;
   logic [2:0]             hit_row;
   logic [3:0]             hit_col;
   logic [N_BRICKS-1:0]    hit_vec;
   logic [BRICK_CNT_W-1:0] bricks_left;
   logic                   all_clear;

   modport master (
      output start, clear_bricks, ball_x, ball_y,
      input  busy, done, hit, hit_row, hit_col, hit_vec, bricks_left, all_clear
   );

   modport slave (
      input  start, clear_bricks, ball_x, ball_y,
      output busy, done, hit, hit_row, hit_col, hit_vec, bricks_left, all_clear
   );
endinterface

// File: rtl/brick_overlap.sv
// Combinational bounding-box test of a square ball against a rectangle.
// Both sides are offset by the half-size so no subtraction can wrap.
module brick_overlap #(
   parameter int W = 11
) (
   input  logic [W-1:0] ball_x_i,
   input  logic [W-1:0] ball_y_i,
   input  logic [W-1:0] half_i,
   input  logic [W-1:0] x0_i,
   input  logic [W-1:0] y0_i,
   input  logic [W-1:0] w_i,
   input  logic [W-1:0] h_i,
   output logic         overlap_o
);
   logic [W-1:0] bx_lo, by_lo, x_hi, y_hi;

   assign bx_lo = ball_x_i + half_i;
   assign by_lo = ball_y_i + half_i;
   assign x_hi  = x0_i + w_i + half_i;
   assign y_hi  = y0_i + h_i + half_i;

   assign overlap_o = (bx_lo >= x0_i) && (ball_x_i <= x_hi) &&
                      (by_lo >= y0_i) && (ball_y_i <= y_hi);
endmodule

// File: rtl/brick_scan_sequencer.sv
// Walks the brick grid one brick per clock after each start, reporting at most
// one newly destroyed brick per scan and owning the brick hit-state vector.
module brick_scan_sequencer
   import breakout_pkg::*;
#(
   parameter int COLS    = BRICK_COLS,
   parameter int ROWS    = BRICK_ROWS,
   parameter int LEFT_X  = BRICK_LEFT_X,
   parameter int TOP_Y   = BRICK_TOP_Y,
   parameter int BRICK_W = breakout_pkg::BRICK_W,
   parameter int BRICK_H = breakout_pkg::BRICK_H,
   parameter int BALL_R  = breakout_pkg::BALL_R
) (
   input logic                  clk,
   input logic                  rst,
   brick_scan_sequencer_if.slave bus
);
   localparam int NB = ROWS * COLS;
   localparam logic [BRICK_IDX_W-1:0] LAST_IDX = BRICK_IDX_W'(NB - 1);
   localparam logic [3:0]             LAST_COL = 4'(COLS - 1);
   localparam logic [BRICK_CNT_W-1:0] FULL_CNT = BRICK_CNT_W'(NB);

   scan_state_e            state_q, state_d;
   logic [COORD_W-1:0]     bx_q, bx_d, by_q, by_d;
   logic [CMP_W-1:0]       x0_q, x0_d, y0_q, y0_d;
   logic [2:0]             row_q, row_d;
   logic [3:0]             col_q, col_d;
   logic [BRICK_IDX_W-1:0] idx_q, idx_d;

   logic [NB-1:0]          hit_vec_q, hit_vec_d;
   logic [BRICK_CNT_W-1:0] bricks_left_q, bricks_left_d;
   logic                   all_clear_q, all_clear_d;
   logic                   done_q, done_d;
   logic                   hit_q, hit_d;
   logic [2:0]             hit_row_q, hit_row_d;
   logic [3:0]             hit_col_q, hit_col_d;
   logic                   overlap;

   brick_overlap #(.W(CMP_W)) u_overlap (
      .ball_x_i  ({1'b0, bx_q}),
      .ball_y_i  ({1'b0, by_q}),
      .half_i    (CMP_W'(BALL_R)),
      .x0_i      (x0_q),
      .y0_i      (y0_q),
      .w_i       (CMP_W'(BRICK_W)),
      .h_i       (CMP_W'(BRICK_H)),
      .overlap_o (overlap)
   );

   always_comb begin
      state_d       = state_q;
      bx_d          = bx_q;
      by_d          = by_q;
      x0_d          = x0_q;
      y0_d          = y0_q;
      row_d         = row_q;
      col_d         = col_q;
      idx_d         = idx_q;
      hit_vec_d     = hit_vec_q;
      bricks_left_d = bricks_left_q;
      done_d        = 1'b0;
      hit_d         = 1'b0;
      hit_row_d     = hit_row_q;
      hit_col_d     = hit_col_q;

      // clear_bricks outranks everything, including a start in the same cycle
      if (bus.clear_bricks) begin
         hit_vec_d     = '0;
         bricks_left_d = FULL_CNT;
         state_d       = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_d = ST_SCAN;
                  bx_d    = bus.ball_x;
                  by_d    = bus.ball_y;
                  row_d   = '0;
                  col_d   = '0;
                  idx_d   = '0;
                  x0_d    = CMP_W'(LEFT_X);
                  y0_d    = CMP_W'(TOP_Y);
               end
            end
            ST_SCAN: begin
               if (overlap && !hit_vec_q[idx_q]) begin
                  hit_vec_d[idx_q] = 1'b1;
                  bricks_left_d    = bricks_left_q - 1'b1;
                  hit_row_d        = row_q;
                  hit_col_d        = col_q;
                  hit_d            = 1'b1;
                  done_d           = 1'b1;
                  state_d          = ST_IDLE;
               end else if (idx_q == LAST_IDX) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
                  if (col_q == LAST_COL) begin
                     col_d = '0;
                     x0_d  = CMP_W'(LEFT_X);
                     row_d = row_q + 1'b1;
                     y0_d  = y0_q + CMP_W'(BRICK_H);
                  end else begin
                     col_d = col_q + 1'b1;
                     x0_d  = x0_q + CMP_W'(BRICK_W);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      all_clear_d = (bricks_left_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         hit_vec_q     <= '0;
         bricks_left_q <= FULL_CNT;
         all_clear_q   <= 1'b0;
         done_q        <= 1'b0;
         hit_q         <= 1'b0;
         hit_row_q     <= '0;
         hit_col_q     <= '0;
      end else begin
         state_q       <= state_d;
         hit_vec_q     <= hit_vec_d;
         bricks_left_q <= bricks_left_d;
         all_clear_q   <= all_clear_d;
         done_q        <= done_d;
         hit_q         <= hit_d;
         hit_row_q     <= hit_row_d;
         hit_col_q     <= hit_col_d;
      end
   end

   // Scan datapath is only meaningful while in SCAN, so it carries no reset
   always_ff @(posedge clk) begin
      bx_q  <= bx_d;
      by_q  <= by_d;
      x0_q  <= x0_d;
      y0_q  <= y0_d;
      row_q <= row_d;
      col_q <= col_d;
      idx_q <= idx_d;
   end

   assign bus.busy        = (state_q == ST_SCAN);
   assign bus.done        = done_q;
   assign bus.hit         = hit_q;
   assign bus.hit_row     = hit_row_q;
   assign bus.hit_col     = hit_col_q;
   assign bus.hit_vec     = hit_vec_q;
   assign bus.bricks_left = bricks_left_q;
   assign bus.all_clear   = all_clear_q;
endmodule

// File: tb/tb_brick_scan_sequencer.sv
// Scoreboard bench for the brick scan sequencer: stimulus queues expected
// scan results, a negedge monitor checks every done pulse against them.
module tb_brick_scan_sequencer;
   import breakout_pkg::*;

   typedef struct {
      bit hit;
      int row;
      int col;
      int lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_total = 0;
   int   n_fail  = 0;
   int   edge_n  = 0;
   int   start_edge = 0;
   exp_t exp_q[$];
   logic [59:0] all_ones;

   brick_scan_sequencer_if #(.N_BRICKS(60)) bus ();

   brick_scan_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_total++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, expected done=0 (t=%0t)", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("done_latency", 64'(edge_n - start_edge), 64'(e.lat));
            chk("hit_flag", 64'(bus.hit), 64'(e.hit));
            if (e.hit) begin
               chk("hit_row", 64'(bus.hit_row), 64'(e.row));
               chk("hit_col", 64'(bus.hit_col), 64'(e.col));
            end
         end
      end
   end

   task automatic wait_done(input int max);
      bit seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      if (!seen) chk("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_scan(input int bx, input int by, input bit h, input int r,
                          input int c, input int lat);
      exp_t e;
      @(negedge clk);
      bus.ball_x = 10'(bx);
      bus.ball_y = 10'(by);
      bus.start  = 1'b1;
      e.hit = h; e.row = r; e.col = c; e.lat = lat;
      exp_q.push_back(e);
      @(posedge clk);
      #1 start_edge = edge_n;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(80);
   endtask

   task automatic chk_state(input string tag, input logic [59:0] vec, input int left,
                            input bit ac);
      chk({tag, "_hit_vec"}, 64'(bus.hit_vec), 64'(vec));
      chk({tag, "_bricks_left"}, 64'(bus.bricks_left), 64'(left));
      chk({tag, "_all_clear"}, 64'(bus.all_clear), 64'(ac));
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t dummy;
      bus.start = 1'b0;
      bus.clear_bricks = 1'b0;
      bus.ball_x = '0;
      bus.ball_y = '0;
      all_ones = '1;
      #1 rst = 1'b1;
      #1;
      chk_state("reset", 60'd0, 60, 1'b0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_hit", 64'(bus.hit), 64'd0);
      chk("reset_hit_row", 64'(bus.hit_row), 64'd0);
      chk("reset_hit_col", 64'(bus.hit_col), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Ball below the brick field: full scan, no hit
      do_scan(480, 200, 1'b0, 0, 0, 60);
      chk_state("miss", 60'd0, 60, 1'b0);

      // Ball on brick (0,0), then again on the now-destroyed brick
      do_scan(252, 37, 1'b1, 0, 0, 1);
      chk_state("hit00", 60'd1, 59, 1'b0);
      do_scan(252, 37, 1'b0, 0, 0, 60);
      chk_state("rehit00", 60'd1, 59, 1'b0);
      chk("hold_hit_row", 64'(bus.hit_row), 64'd0);

      // Ball straddles four bricks; mid-scan ball moves must be ignored
      fork
         do_scan(295, 110, 1'b1, 2, 0, 25);
         begin
            @(posedge clk);
            #2 bus.ball_x = 10'd480;
            bus.ball_y = 10'd200;
         end
      join
      chk_state("hit24", 60'h000_0000_0100_0001, 58, 1'b0);
      do_scan(295, 110, 1'b1, 2, 1, 26);
      chk_state("hit25", 60'h000_0000_0300_0001, 57, 1'b0);
      chk("hold_hit_col", 64'(bus.hit_col), 64'd1);

      // clear_bricks in the first scan cycle aborts without a done pulse
      @(negedge clk);
      bus.ball_x = 10'd252;
      bus.ball_y = 10'd37;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.clear_bricks = 1'b1;
      @(negedge clk);
      bus.clear_bricks = 1'b0;
      chk_state("abort", 60'd0, 60, 1'b0);
      chk("abort_done", 64'(bus.done), 64'd0);

      // start together with clear_bricks is dropped
      bus.start = 1'b1;
      bus.clear_bricks = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.clear_bricks = 1'b0;
      chk("clr_start_busy", 64'(bus.busy), 64'd0);

      // A second start while busy must not queue a second scan
      @(negedge clk);
      bus.ball_x = 10'd480;
      bus.ball_y = 10'd200;
      bus.start = 1'b1;
      dummy.hit = 1'b0; dummy.row = 0; dummy.col = 0; dummy.lat = 60;
      exp_q.push_back(dummy);
      @(posedge clk);
      #1 start_edge = edge_n;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      chk("busy_mid_scan", 64'(bus.busy), 64'd1);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(80);
      repeat (70) @(negedge clk);
      chk("no_queued_scan", 64'(exp_q.size()), 64'd0);

      // Sweep the ball over every brick centre
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 12; c++)
            do_scan(272 + 45 * c, 47 + 25 * r, 1'b1, r, c, r * 12 + c + 1);
      chk_state("sweep", all_ones, 0, 1'b1);
      do_scan(272, 47, 1'b0, 0, 0, 60);
      chk_state("allclr_scan", all_ones, 0, 1'b1);
      @(negedge clk);
      bus.clear_bricks = 1'b1;
      @(negedge clk);
      bus.clear_bricks = 1'b0;
      chk_state("rearm", 60'd0, 60, 1'b0);

      // Asynchronous reset in the middle of a scan
      do_scan(252, 37, 1'b1, 0, 0, 1);
      @(negedge clk);
      bus.ball_x = 10'd480;
      bus.ball_y = 10'd200;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      chk("pre_rst_busy", 64'(bus.busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk_state("async_rst", 60'd0, 60, 1'b0);
      chk("async_rst_done", 64'(bus.done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (70) @(negedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end
endmodule
